// File: rtl/usb_tx_arb_pkg.sv
// usb_tx_arb_pkg: shared types and constants for the USB full-speed transmit arbiter
//   arb_state_e : arbiter FSM states (IDLE, START, BUSY, GAP)
//   PID_W       : PID width in bits
//   DATA_W      : data byte width in bits
//   oh_idx      : index of the set bit in a one-hot vector of up to 8 bits
package usb_tx_arb_pkg;
   typedef enum logic [1:0] {IDLE, START, BUSY, GAP} arb_state_e;
   localparam int PID_W = 4;
   localparam int DATA_W = 8;
   function automatic int oh_idx(input logic [7:0] oh);
      oh_idx = 0;
      for (int i = 0; i < 8; i++) if (oh[i]) oh_idx = i;
   endfunction
endpackage

// File: rtl/usb_rr_pick.sv
// usb_rr_pick: combinational round-robin one-hot selector
//   req   in  NUM_REQ          request vector
//   ptr   in  clog2(NUM_REQ)   first index to consider, search wraps circularly
//   pick  out NUM_REQ          one-hot winner, 0 when no request
//   valid out 1                any request present
module usb_rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         pick,
   output logic                       valid
);
   // Scan from the far end back towards ptr so the closest request wins.
   always_comb begin
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % NUM_REQ]) pick = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
   end
   assign valid = |req;
endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// usb_fs_tx_arbiter: round-robin sharing of one USB FS packet transmitter among NUM_REQ sources
//   clk, reset_n              clock, asynchronous active-low reset
//   req/req_pid/req_data_avail/req_data   per-requester request, PID and byte stream
//   req_data_get, grant, done per-requester byte pull, one-hot grant, end-of-packet pulse
//   timeout                   abort pulse (busy watchdog)
//   tx_pkt_start/tx_pid/tx_data_avail/tx_data/tx_data_get/tx_pkt_end  transmitter side
//   Macro USB_TX_ARB_TIMEOUT_EN enables the TIMEOUT_CYCLES busy watchdog.
module usb_fs_tx_arbiter
   import usb_tx_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [PID_W*NUM_REQ-1:0]  req_pid,
   input  logic [NUM_REQ-1:0]        req_data_avail,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_data_get,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic                      timeout,
   output logic                      tx_pkt_start,
   output logic [PID_W-1:0]          tx_pid,
   output logic                      tx_data_avail,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_data_get,
   input  logic                      tx_pkt_end
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   arb_state_e state, state_n;
   logic [PW-1:0] rr_ptr;
   logic [GW-1:0] gap_cnt;
   logic [NUM_REQ-1:0] pick;
   logic valid, fin, abort;
   int g, p;
   usb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req), .ptr(rr_ptr), .pick(pick), .valid(valid));
   assign g = oh_idx(8'(grant));
   assign p = oh_idx(8'(pick));
   assign tx_pkt_start = state == START;
   assign req_data_get = tx_data_get ? grant : '0;
   assign tx_data_avail = |(grant & req_data_avail);
   assign tx_data = |grant ? req_data[g*DATA_W +: DATA_W] : '0;
   assign fin = state == BUSY && (tx_pkt_end || abort);
`ifdef USB_TX_ARB_TIMEOUT_EN
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] busy_cnt;
   // A tx_pkt_end on the limit cycle wins: it is a normal completion.
   assign abort = state == BUSY && !tx_pkt_end && busy_cnt == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) busy_cnt <= '0;
      else if (state == START) busy_cnt <= '0;
      else if (state == BUSY) busy_cnt <= busy_cnt + TW'(1);
`else
   logic timeout_unused;
   assign timeout_unused = TIMEOUT_CYCLES != 0;
   assign abort = 1'b0;
`endif
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = valid ? START : IDLE;
         START:   state_n = BUSY;
         BUSY:    state_n = fin ? (GAP_CYCLES == 0 ? IDLE : GAP) : BUSY;
         default: state_n = gap_cnt == '0 ? IDLE : GAP;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant   <= '0;
         done    <= '0;
         timeout <= 1'b0;
         tx_pid  <= '0;
         rr_ptr  <= '0;
         gap_cnt <= '0;
      end else begin
         done    <= '0;
         timeout <= 1'b0;
         if (state == IDLE && valid) begin
            grant  <= pick;
            tx_pid <= req_pid[p*PID_W +: PID_W];
         end
         if (fin) begin
            done    <= grant;
            timeout <= abort;
            grant   <= '0;
            rr_ptr  <= PW'((g + 1) % NUM_REQ);
            gap_cnt <= GW'(GAP_CYCLES - 1);
         end else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      end
   end
endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// tb_usb_fs_tx_arbiter: directed self-checking bench for usb_fs_tx_arbiter (NUM_REQ=4, GAP_CYCLES=8, TIMEOUT_CYCLES=16)
module tb_usb_fs_tx_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] req, req_data_avail, req_data_get, grant, done;
  logic [15:0] req_pid;
  logic [31:0] req_data;
  logic timeout, tx_pkt_start, tx_data_avail, tx_data_get, tx_pkt_end;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  usb_fs_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_pid(req_pid),
    .req_data_avail(req_data_avail), .req_data(req_data), .req_data_get(req_data_get),
    .grant(grant), .done(done), .timeout(timeout), .tx_pkt_start(tx_pkt_start),
    .tx_pid(tx_pid), .tx_data_avail(tx_data_avail), .tx_data(tx_data),
    .tx_data_get(tx_data_get), .tx_pkt_end(tx_pkt_end));
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_start(output int n);
    n = 0;
    while (tx_pkt_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("start_seen", n < 50, 1'b1);
  endtask
  task automatic pkt(input logic [3:0] eg, input logic [3:0] ep, input int len, output int n);
    wait_start(n);
    chk("pkt_grant", grant, eg);
    chk("pkt_pid", tx_pid, ep);
    tick();
    chk("pkt_start_fall", tx_pkt_start, 1'b0);
    chk("pkt_grant_hold", grant, eg);
    repeat (len) tick();
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("pkt_done", done, eg);
    chk("pkt_grant_clr", grant, 4'b0000);
  endtask
  initial begin
    int n;
    reset_n = 1'b0;
    req = '0;
    req_pid = '0;
    req_data_avail = '0;
    req_data = '0;
    tx_data_get = 1'b0;
    tx_pkt_end = 1'b0;
    repeat (2) tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_start", tx_pkt_start, 1'b0);
    chk("rst_pid", tx_pid, 4'h0);
    chk("rst_get", req_data_get, 4'b0000);
    chk("rst_avail", tx_data_avail, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    reset_n = 1'b1;
    tick();
    req_pid = 16'h0300;
    req = 4'b0100;
    tick();
    chk("s_start", tx_pkt_start, 1'b1);
    chk("s_grant", grant, 4'b0100);
    chk("s_pid", tx_pid, 4'b0011);
    req_pid = 16'h0F00;
    tick();
    chk("s_start_fall", tx_pkt_start, 1'b0);
    chk("s_grant_busy", grant, 4'b0100);
    chk("s_pid_latched", tx_pid, 4'b0011);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    req = 4'b0000;
    chk("s_done", done, 4'b0100);
    chk("s_grant_clr", grant, 4'b0000);
    tick();
    chk("s_done_pulse", done, 4'b0000);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("gap_spurious_done", done, 4'b0000);
    chk("gap_spurious_start", tx_pkt_start, 1'b0);
    req_data_avail = 4'b1111;
    req_data = 32'h44332211;
    tx_data_get = 1'b1;
    #1;
    chk("nogrant_get", req_data_get, 4'b0000);
    chk("nogrant_data", tx_data, 8'h00);
    chk("nogrant_avail", tx_data_avail, 1'b0);
    tx_data_get = 1'b0;
    repeat (10) tick();
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("idle_spurious_done", done, 4'b0000);
    chk("idle_spurious_grant", grant, 4'b0000);
    chk("idle_spurious_start", tx_pkt_start, 1'b0);
    req_pid = 16'h4321;
    req = 4'b1111;
    pkt(4'b1000, 4'd4, 3, n);
    pkt(4'b0001, 4'd1, 2, n);
    chk("rr_gap1", n, 9);
    pkt(4'b0010, 4'd2, 1, n);
    chk("rr_gap2", n, 9);
    pkt(4'b0100, 4'd3, 4, n);
    chk("rr_gap3", n, 9);
    req = 4'b0010;
    req_data = 32'hDDCCBBAA;
    req_data_avail = 4'b0010;
    wait_start(n);
    chk("d_gap", n, 9);
    chk("d_grant", grant, 4'b0010);
    tick();
    chk("d_data", tx_data, 8'hBB);
    chk("d_avail", tx_data_avail, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tx_data_get = 1'b1;
      #1;
      chk("d_get_hi", req_data_get, 4'b0010);
      tx_data_get = 1'b0;
      #1;
      chk("d_get_lo", req_data_get, 4'b0000);
      tick();
    end
    req_data = 32'hDDCC5AAA;
    #1;
    chk("d_track", tx_data, 8'h5A);
    req = 4'b0000;
    tick();
    chk("d_drop_grant", grant, 4'b0010);
    chk("d_drop_avail", tx_data_avail, 1'b1);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("d_done", done, 4'b0010);
    req = 4'b0010;
    wait_start(n);
    chk("rereq_gap", n, 9);
    chk("rereq_grant", grant, 4'b0010);
    tick();
    chk("rereq_busy", grant, 4'b0010);
    reset_n = 1'b0;
    #1;
    chk("ar_grant", grant, 4'b0000);
    chk("ar_start", tx_pkt_start, 1'b0);
    chk("ar_pid", tx_pid, 4'h0);
    chk("ar_data", tx_data, 8'h00);
    chk("ar_avail", tx_data_avail, 1'b0);
    chk("ar_done", done, 4'b0000);
    tick();
    req = 4'b1111;
    reset_n = 1'b1;
    pkt(4'b0001, 4'd1, 2, n);
    chk("ar_first_wait", n, 1);
    pkt(4'b0010, 4'd2, 2, n);
    chk("ar_gap1", n, 9);
    pkt(4'b0100, 4'd3, 2, n);
    chk("ar_gap2", n, 9);
    pkt(4'b1000, 4'd4, 2, n);
    chk("ar_gap3", n, 9);
    pkt(4'b0001, 4'd1, 2, n);
    chk("ar_gap4", n, 9);
    req = 4'b0100;
    wait_start(n);
    chk("to_grant", grant, 4'b0100);
`ifdef USB_TX_ARB_TIMEOUT_EN
    repeat (16) tick();
    chk("to_pre", timeout, 1'b0);
    chk("to_pre_grant", grant, 4'b0100);
    tick();
    chk("to_pulse", timeout, 1'b1);
    chk("to_done", done, 4'b0100);
    chk("to_grant_clr", grant, 4'b0000);
    tick();
    chk("to_pulse_end", timeout, 1'b0);
    wait_start(n);
    chk("to_gap", n, 8);
    repeat (16) tick();
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("to_edge_done", done, 4'b0100);
    chk("to_edge_timeout", timeout, 1'b0);
`else
    repeat (40) tick();
    chk("nto_timeout", timeout, 1'b0);
    chk("nto_grant", grant, 4'b0100);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("nto_done", done, 4'b0100);
    chk("nto_timeout_end", timeout, 1'b0);
`endif
    req = 4'b0000;
    repeat (12) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
